// File: rtl/aes_nmr_enc.sv
// AES-128 encryptor: N_COPY redundant one-round-per-clock datapaths, shared on-the-fly key schedule, bitwise majority vote.
// Build option AES_NMR_ERRCNT_EN adds the saturating ErrCnt fault counter port.
module aes_nmr_enc #(
    parameter int N_COPY = 3,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic [127:0]      Kin,
    input  logic [127:0]      Din,
    input  logic              Krdy,
    input  logic              Drdy,
    input  logic              Red,
    input  logic [N_COPY-1:0] Inj,
    output logic [127:0]      Dout,
    output logic              Kvld,
    output logic              Dvld,
    output logic              BSY,
    output logic              Flt
`ifdef AES_NMR_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]  ErrCnt
`endif
);
    localparam int IW = (N_COPY > 1) ? $clog2(N_COPY) : 1;

    generate
        if (N_COPY != 1 && N_COPY != 3 && N_COPY != 5) begin : g_bad_ncopy
            $error("aes_nmr_enc: N_COPY must be 1, 3 or 5");
        end
        if (CNT_W < 1) begin : g_bad_cntw
            $error("aes_nmr_enc: CNT_W must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t       state;
    logic [127:0] key_q, rk_q, rk_nxt, key_use, voted;
    logic [7:0]   rcon_q;
    logic [3:0]   rnd_q;
    logic         red_q, start, mis;
    logic [127:0] st_q [N_COPY];
    logic [127:0] st_d [N_COPY];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int unsigned k = 0; k < 8; k++) begin
            if (b[3'(k)]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv;
        sq  = a;
        inv = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [15:0][7:0] sb, sr, o;
        logic [7:0] a0, a1, a2, a3;
        sb = s;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                sr[4'(15 - 4*c - r)] = sbox(sb[4'(15 - 4*((c + r) % 4) - r)]);
        o = sr;
        if (!last) begin
            for (int unsigned c = 0; c < 4; c++) begin
                a0 = sr[4'(15 - 4*c)];
                a1 = sr[4'(14 - 4*c)];
                a2 = sr[4'(13 - 4*c)];
                a3 = sr[4'(12 - 4*c)];
                o[4'(15 - 4*c)] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                o[4'(14 - 4*c)] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                o[4'(13 - 4*c)] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                o[4'(12 - 4*c)] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        return o ^ rk;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_comb begin
        int unsigned cnt;
        cnt     = 0;
        start   = Drdy && (state != ROUND);
        key_use = (state == IDLE && Krdy) ? Kin : key_q;
        rk_nxt  = key_next(rk_q, rcon_q);
        for (int unsigned i = 0; i < N_COPY; i++) begin
            st_d[IW'(i)] = '0;
            if (i == 0 || red_q)
                st_d[IW'(i)] = aes_round(st_q[IW'(i)], rk_nxt, rnd_q == 4'd10)
                               ^ {127'h0, Inj[IW'(i)]};
        end
        voted = st_d[0];
        mis   = 1'b0;
        // Vote and mismatch are taken on the final-round values so Dout/Flt register with Dvld
        if (red_q && N_COPY > 1) begin
            for (int unsigned b = 0; b < 128; b++) begin
                cnt = 0;
                for (int unsigned i = 0; i < N_COPY; i++)
                    cnt = cnt + {31'h0, st_d[IW'(i)][7'(b)]};
                voted[7'(b)] = (cnt > N_COPY / 2);
            end
            for (int unsigned i = 0; i < N_COPY; i++)
                if (st_d[IW'(i)] != voted) mis = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= IDLE;
            key_q  <= '0;
            rk_q   <= '0;
            rcon_q <= 8'h01;
            rnd_q  <= '0;
            red_q  <= 1'b0;
            for (int unsigned i = 0; i < N_COPY; i++) st_q[IW'(i)] <= '0;
            Dout   <= '0;
            Kvld   <= 1'b0;
            Dvld   <= 1'b0;
            BSY    <= 1'b0;
            Flt    <= 1'b0;
`ifdef AES_NMR_ERRCNT_EN
            ErrCnt <= '0;
`endif
        end else if (EN) begin
            Kvld <= 1'b0;
            case (state)
                IDLE: begin
                    if (Krdy) begin
                        key_q <= Kin;
                        rk_q  <= Kin;
                        Kvld  <= 1'b1;
                    end
                end
                ROUND: begin
                    for (int unsigned i = 0; i < N_COPY; i++) st_q[IW'(i)] <= st_d[IW'(i)];
                    rk_q   <= rk_nxt;
                    rcon_q <= xt(rcon_q);
                    rnd_q  <= rnd_q + 4'd1;
                    if (rnd_q == 4'd10) begin
                        state <= DONE;
                        Dvld  <= 1'b1;
                        BSY   <= 1'b0;
                        Dout  <= voted;
                        Flt   <= mis;
`ifdef AES_NMR_ERRCNT_EN
                        if (mis && ErrCnt != '1) ErrCnt <= ErrCnt + CNT_W'(1);
`endif
                    end
                end
                DONE: begin
                    Dvld   <= 1'b0;
                    rk_q   <= key_q;
                    rcon_q <= 8'h01;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A start overrides the per-state updates above (IDLE key load already folded into key_use)
            if (start) begin
                for (int unsigned i = 0; i < N_COPY; i++)
                    st_q[IW'(i)] <= (i == 0 || Red) ? (Din ^ key_use) : '0;
                rk_q   <= key_use;
                rcon_q <= 8'h01;
                red_q  <= Red;
                rnd_q  <= 4'd1;
                Dvld   <= 1'b0;
                Flt    <= 1'b0;
                BSY    <= 1'b1;
                state  <= ROUND;
            end
        end
    end
endmodule

// File: tb/tb_aes_nmr_enc.sv
// Bench for aes_nmr_enc: table-driven AES reference with per-copy fault masks and a cycle-level handshake model,
// compared against the DUT on every falling edge, plus directed literal checks.
`timescale 1ns/1ps
module tb_aes_nmr_enc;
    localparam int NC = 3;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic          CLK = 1'b0, RSTn = 1'b0, EN = 1'b0, Krdy = 1'b0, Drdy = 1'b0, Red = 1'b0;
    logic [127:0]  Kin = '0, Din = '0;
    logic [NC-1:0] Inj = '0;
    logic [127:0]  Dout;
    logic          Kvld, Dvld, BSY, Flt;
`ifdef AES_NMR_ERRCNT_EN
    logic [7:0]    ErrCnt;
`endif

    aes_nmr_enc #(.N_COPY(NC), .CNT_W(8)) dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN), .Kin(Kin), .Din(Din), .Krdy(Krdy), .Drdy(Drdy),
        .Red(Red), .Inj(Inj), .Dout(Dout), .Kvld(Kvld), .Dvld(Dvld), .BSY(BSY), .Flt(Flt)
`ifdef AES_NMR_ERRCNT_EN
        , .ErrCnt(ErrCnt)
`endif
    );

    always #5 CLK = ~CLK;

    int tests = 0, fails = 0, cyc = 0, lat, n, t_first;
    bit mon_en = 1'b0;
    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {127'h0, act}, {127'h0, exp});
    endtask

    task automatic chki(input string name, input int act, input int exp);
        chk(name, 128'(act), 128'(exp));
    endtask

    logic [2047:0] sbox_tab = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [7:0] sb(input logic [7:0] v);
        return sbox_tab[2047 - 8*int'(v) -: 8];
    endfunction

    function automatic logic [7:0] m2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Reference AES-128 with a precomputed schedule; mask[r] flips bit 0 of the state after round r
    function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] pt,
                                             input logic [10:0] mask);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [31:0]  tw;
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {sb(tw[23:16]), sb(tw[15:8]), sb(tw[7:0]), sb(tw[31:24])} ^ {rc, 24'h0};
                rc = m2(rc);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sb(s[r][(c+r)%4]);
            for (int c = 0; c < 4; c++) begin
                if (rd < 10) begin
                    s[0][c] = m2(t[0][c]) ^ m2(t[1][c]) ^ t[1][c] ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ m2(t[1][c]) ^ m2(t[2][c]) ^ t[2][c] ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ m2(t[2][c]) ^ m2(t[3][c]) ^ t[3][c];
                    s[3][c] = m2(t[0][c]) ^ t[0][c] ^ t[1][c] ^ t[2][c] ^ m2(t[3][c]);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
            end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
            if (mask[rd]) s[3][3] = s[3][3] ^ 8'h01;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    // Handshake model: m_cnt counts remaining rounds, the Dvld cycle is the only post-block cycle
    logic [127:0] m_key, m_run_key, m_pt, m_dout;
    logic [127:0] m_res [NC];
    logic [10:0]  m_mask [NC];
    logic         m_kvld, m_dvld, m_flt, m_red, was_done;
    logic [7:0]   m_err;
    int           m_cnt, nact, ones;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_key = '0; m_dout = '0; m_kvld = 0; m_dvld = 0; m_flt = 0; m_red = 0;
            m_cnt = 0; m_err = '0;
        end else if (EN) begin
            was_done = m_dvld;
            m_kvld   = 0;
            m_dvld   = 0;
            if (m_cnt > 0) begin
                for (int i = 0; i < NC; i++)
                    if (Inj[i] && (i == 0 || m_red)) m_mask[i][11-m_cnt] = 1'b1;
                if (m_cnt == 1) begin
                    nact = m_red ? NC : 1;
                    for (int i = 0; i < nact; i++) m_res[i] = ref_enc(m_run_key, m_pt, m_mask[i]);
                    for (int b = 0; b < 128; b++) begin
                        ones = 0;
                        for (int i = 0; i < nact; i++) ones += int'(m_res[i][b]);
                        m_dout[b] = (2*ones > nact);
                    end
                    m_flt = 0;
                    for (int i = 0; i < nact; i++) if (m_res[i] != m_dout) m_flt = 1;
                    m_dvld = 1;
                    if (m_flt && m_err != 8'hff) m_err = m_err + 8'd1;
                end
                m_cnt--;
            end else begin
                if (Krdy && !was_done) begin
                    m_key  = Kin;
                    m_kvld = 1;
                end
                if (Drdy) begin
                    m_cnt = 10; m_pt = Din; m_run_key = m_key; m_red = Red; m_flt = 0;
                    for (int i = 0; i < NC; i++) m_mask[i] = '0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            chkb("Kvld", Kvld, m_kvld);
            chkb("Dvld", Dvld, m_dvld);
            chkb("BSY", BSY, m_cnt != 0);
            chkb("Flt", Flt, m_flt);
            chk("Dout", Dout, m_dout);
`ifdef AES_NMR_ERRCNT_EN
            chk("ErrCnt", {120'h0, ErrCnt}, {120'h0, m_err});
`endif
            if (m_cnt != 0 && !m_red) chk("idle_copies", dut.st_q[1] | dut.st_q[2], '0);
        end
    end

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_dvld(input string name, output int cnt);
        cnt = 0;
        while (!Dvld && cnt < 20) begin
            tick();
            cnt++;
        end
        chkb(name, Dvld, 1'b1);
    endtask

    // kmode: 0 keep key, 1 load key beforehand, 2 load key together with Drdy
    task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input logic red,
                             input logic [NC-1:0] inj, input int inj_r, input int kmode,
                             input int en_off, output int cnt);
        if (kmode == 1) begin
            Krdy = 1; Kin = key; tick(); Krdy = 0; tick();
        end
        if (kmode == 2) begin
            Krdy = 1; Kin = key;
        end
        Din = pt; Red = red; Drdy = 1; tick(); Drdy = 0; Krdy = 0;
        cnt = 0;
        while (cnt < 20) begin
            Inj = (cnt == inj_r - 1) ? inj : '0;
            if (en_off > 0 && cnt == en_off) EN = 0;
            if (en_off > 0 && cnt == en_off + 3) EN = 1;
            tick();
            cnt++;
            if (Dvld) break;
        end
        Inj = '0;
        EN  = 1;
        chkb("dvld_seen", Dvld, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        chk("ref_C1", ref_enc(K1, P1, '0), C1);
        chk("ref_C2", ref_enc(K2, P2, '0), C2);
        tick(2);
        mon_en = 1;
        chk("rst_dout", Dout, '0);
        chkb("rst_bsy", BSY, 1'b0);
        RSTn = 1; EN = 1; tick();

        run_block(K1, P1, 1'b1, '0, 0, 1, 0, lat);
        chki("t1_lat", lat, 10); chk("t1_dout", Dout, C1); chkb("t1_flt", Flt, 1'b0);
        tick();

        run_block(K2, P2, 1'b1, 3'b010, 5, 1, 0, lat);
        chki("t2_lat", lat, 10); chk("t2_dout", Dout, C2); chkb("t2_flt", Flt, 1'b1);
`ifdef AES_NMR_ERRCNT_EN
        chk("t2_errcnt", {120'h0, ErrCnt}, 128'd1);
`endif
        tick();

        run_block(K2, P2, 1'b1, 3'b011, 5, 0, 0, lat);
        chkb("t3_dout_ne", Dout != C2, 1'b1); chkb("t3_flt", Flt, 1'b1);
        tick();

        run_block(K2, P2, 1'b0, 3'b100, 5, 0, 0, lat);
        chk("t4_dout", Dout, C2); chkb("t4_flt", Flt, 1'b0);
        chk("t4_copies", dut.st_q[1] | dut.st_q[2], '0);
        tick();

        Krdy = 1; Kin = K1; tick(); Krdy = 0; tick();
        Din = P1; Red = 1; Drdy = 1; tick(); Drdy = 0;
        tick(3);
        Drdy = 1; Din = P2; Krdy = 1; Kin = K2; tick(); Drdy = 0; Krdy = 0;
        chkb("t5_no_kvld", Kvld, 1'b0);
        wait_dvld("t5_dvld1", n);
        chk("t5_first", Dout, C1);
        t_first = cyc;
        Din = P1; Drdy = 1; tick(); Drdy = 0;
        wait_dvld("t5_dvld2", n);
        chki("t5_spacing", cyc - t_first, 11);
        chk("t5_second", Dout, C1);
        tick();

        Din = P1; Red = 1; Drdy = 1; tick(); Drdy = 0; tick(5);
        RSTn = 0; tick();
        chk("t6_rst_dout", Dout, '0); chkb("t6_rst_bsy", BSY, 1'b0); chkb("t6_rst_dvld", Dvld, 1'b0);
        tick(2); RSTn = 1; tick(12);
        run_block(K1, P1, 1'b1, '0, 0, 2, 0, lat);
        chki("t6_lat", lat, 10); chk("t6_dout", Dout, C1);
        tick();
        run_block(K1, P1, 1'b1, '0, 0, 0, 4, lat);
        chki("t6_en_lat", lat, 13); chk("t6_en_dout", Dout, C1);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
